// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader slice.
// Holds the RAM geometry, the loader FSM state encoding, the reset PC
// value used by the fetch stage, and a small address helper for the
// wrapping big-endian read.
package imem_pkg;

    // Instruction RAM size in bytes; must be a power of two so that byte
    // address arithmetic wraps naturally at ADDR_W bits.
    localparam int MEM_BYTES = 512;
    localparam int ADDR_W    = 9;

    // Loader FSM state encoding.
    localparam logic [2:0] IDLE_ENC  = 3'd0;
    localparam logic [2:0] CLEAR_ENC = 3'd1;
    localparam logic [2:0] LOAD_ENC  = 3'd2;
    localparam logic [2:0] DONE_ENC  = 3'd3;
    localparam logic [2:0] ERR_ENC   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE_ENC,
        S_CLEAR = CLEAR_ENC,
        S_LOAD  = LOAD_ENC,
        S_DONE  = DONE_ENC,
        S_ERR   = ERR_ENC
    } loader_state_t;

    // PC value the fetch stage starts from once cpu_hold is released.
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Highest byte address in the RAM.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    // Byte address a+off, wrapping modulo MEM_BYTES.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0]        off);
        return a + ADDR_W'(off);
    endfunction

endpackage

// File: rtl/imem_ram_bp.sv
// Byte-wide instruction RAM with one synchronous write port and a
// combinational 4-byte big-endian read port.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write byte address
//   wdata  - write byte
//   raddr  - read byte address (no alignment requirement)
//   rdata  - {mem[raddr], mem[raddr+1], mem[raddr+2], mem[raddr+3]},
//            the +1..+3 addresses wrapping modulo MEM_BYTES
// Contents are deliberately not reset; the loader clears the array
// itself before each program load.
module imem_ram_bp
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [7:0] mem [MEM_BYTES];

    // A read of a byte being written this cycle sees the old value; the
    // new byte appears after the edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = {mem[raddr],
                 mem[wrap_add(raddr, 2'd1)],
                 mem[wrap_add(raddr, 2'd2)],
                 mem[wrap_add(raddr, 2'd3)]};
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: serial byte-stream write side of the
// fetch-stage instruction RAM, plus the IF-stage word read port.
// A start request clears the whole RAM, then accepts program bytes in
// order until in_last; the pipeline is held until the load completes.
// Ports:
//   clk        - clock
//   R          - asynchronous active-low reset
//   start      - one-cycle request to begin a (re)load
//   in_valid   - byte stream valid
//   in_data    - byte stream data, MSB byte of each word first
//   in_last    - final program byte, qualified by in_valid
//   in_ready   - loader accepts a byte this cycle
//   A          - fetch byte address
//   I          - big-endian instruction word at A
//   cpu_hold   - holds PC/nPC and clears IF/ID while high
//   done       - program loaded, pipeline released
//   ovf_err    - stream ran past the end of the RAM without in_last
//   byte_count - bytes accepted in the current/last load
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] A,
    output logic [31:0]       I,
    output logic              cpu_hold,
    output logic              done,
    output logic              ovf_err,
    output logic [ADDR_W:0]   byte_count
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W:0]   byte_count_q, byte_count_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              ovf_err_q, ovf_err_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic              accept;

    // in_ready_q is high exactly in LOAD, so this is the handshake.
    assign accept = in_valid && in_ready_q;

    // Next-state, pointer and RAM write-port logic. The status outputs
    // are decoded from the next state and registered, so they are pure
    // functions of the current state with no path from the inputs.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        clr_ptr_d    = clr_ptr_q;
        byte_count_d = byte_count_q;
        ram_we       = 1'b0;
        ram_waddr    = wptr_q;
        ram_wdata    = in_data;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_CLEAR;
                    wptr_d       = '0;
                    clr_ptr_d    = '0;
                    byte_count_d = '0;
                end
            end
            S_CLEAR: begin
                // One byte zeroed per cycle so a short program leaves no
                // stale bytes from a previous load.
                ram_we    = 1'b1;
                ram_waddr = clr_ptr_q;
                ram_wdata = 8'h00;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ram_we       = 1'b1;
                    ram_waddr    = wptr_q;
                    wptr_d       = wptr_q + 1'b1;
                    byte_count_d = byte_count_q + 1'b1;
                    // in_last wins over overflow: a program that exactly
                    // fills the RAM is a legal load.
                    if (in_last) begin
                        state_d = S_DONE;
                    end else if (wptr_q == LAST_ADDR) begin
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD);
        done_d     = (state_d == S_DONE);
        ovf_err_d  = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    // FSM state, pointers and registered status outputs.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            clr_ptr_q    <= '0;
            byte_count_q <= '0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            ovf_err_q    <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            clr_ptr_q    <= clr_ptr_d;
            byte_count_q <= byte_count_d;
            in_ready_q   <= in_ready_d;
            done_q       <= done_d;
            ovf_err_q    <= ovf_err_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign done       = done_q;
    assign ovf_err    = ovf_err_q;
    assign cpu_hold   = cpu_hold_q;
    assign byte_count = byte_count_q;

    imem_ram_bp u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (A),
        .rdata (I)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. The stimulus process queues the
// expected response; a monitor process pops each entry on the falling
// edge, drives the fetch address it names, and compares the DUT.
module tb_imem_loader;

    logic        clk;
    logic        R;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [8:0]  A;
    logic [31:0] I;
    logic        cpu_hold;
    logic        done;
    logic        ovf_err;
    logic [9:0]  byte_count;

    int checks = 0;
    int errors = 0;

    // kind 0 compares the word I at addr; kind 1 compares packed status
    // {cpu_hold, done, in_ready, ovf_err, byte_count}.
    typedef struct {
        int          kind;
        logic [8:0]  addr;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb[$];

    imem_loader dut (
        .clk        (clk),
        .R          (R),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .A          (A),
        .I          (I),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .ovf_err    (ovf_err),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] st(input logic h, input logic d, input logic r,
                                       input logic o, input int cnt);
        logic [9:0] c;
        c = 10'(cnt);
        return {18'd0, h, d, r, o, c};
    endfunction

    // Monitor: pops one expectation per falling edge and compares.
    initial begin
        sb_item_t    item;
        logic [31:0] act;
        A = '0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                A = item.addr;
                #1;
                if (item.kind == 0) begin
                    act = I;
                end else begin
                    act = {18'd0, cpu_hold, done, in_ready, ovf_err, byte_count};
                end
                checks++;
                if (act !== item.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got %08h expected %08h", item.name, act, item.exp);
                end
            end
        end
    end

    // Queue an expectation and wait (bounded) for the monitor to take it.
    task automatic checkOutput(input int kind, input logic [8:0] addr,
                               input logic [31:0] exp, input string name);
        int n;
        sb_item_t item;
        item.kind = kind;
        item.addr = addr;
        item.exp  = exp;
        item.name = name;
        sb.push_back(item);
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL monitor_stall: %s not consumed", name);
            sb.delete();
        end
    endtask

    // Offer one byte after gap idle cycles; wait for the handshake.
    task automatic applyStimulus(input logic [7:0] b, input logic last, input int gap);
        logic ok;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        ok = 1'b0;
        for (int n = 0; n < 8 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL handshake: byte %02h in_ready=0 expected 1", b);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait out the CLEAR pass (bounded).
    task automatic waitReady();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            seen = in_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL clear_timeout: in_ready=0 expected 1 within 600 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] basic_bytes [8];
        logic [7:0] part_bytes  [5];
        int         part_gaps   [5];
        logic [7:0] last_bytes  [4];

        basic_bytes = '{8'h8A, 8'h00, 8'h40, 8'h01, 8'h82, 8'h10, 8'h60, 8'h02};
        part_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        part_gaps   = '{2, 0, 3, 1, 2};
        last_bytes  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        R        = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        R = 1'b1;
        checkOutput(1, 9'd0, st(1, 0, 0, 0, 0), "reset_status");
        repeat (20) @(posedge clk);
        #1;
        checkOutput(1, 9'd0, st(1, 0, 0, 0, 0), "idle_status");

        // Basic 8-byte load
        pulseStart();
        checkOutput(1, 9'd0, st(1, 0, 0, 0, 0), "clear_status");
        waitReady();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(basic_bytes[i], i == 7, 0);
        end
        checkOutput(1, 9'd0, st(0, 1, 0, 0, 8), "basic_status");
        checkOutput(0, 9'd0, 32'h8A004001, "basic_word0");
        checkOutput(0, 9'd4, 32'h82106002, "basic_word4");

        // Stalls and partial final word
        pulseStart();
        waitReady();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(part_bytes[i], i == 4, part_gaps[i]);
        end
        checkOutput(1, 9'd0, st(0, 1, 0, 0, 5), "partial_status");
        checkOutput(0, 9'd0, 32'h11223344, "partial_word0");
        checkOutput(0, 9'd4, 32'hAB000000, "partial_word4");
        checkOutput(0, 9'd8, 32'h00000000, "partial_word8");

        // Overflow: 512 bytes without in_last
        pulseStart();
        waitReady();
        for (int i = 0; i < 512; i++) begin
            applyStimulus(8'(i) ^ 8'hA5, 1'b0, 0);
        end
        checkOutput(1, 9'd0, st(1, 0, 0, 1, 512), "ovf_status");
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput(1, 9'd0, st(1, 0, 0, 1, 512), "ovf_no_accept");
        in_valid = 1'b0;
        checkOutput(0, 9'd0,   32'hA5A4A7A6, "ovf_word0");
        checkOutput(0, 9'd508, 32'h59585B5A, "ovf_word508");

        // Full 512-byte load from ERR, then wrap read and reload
        pulseStart();
        checkOutput(1, 9'd0, st(1, 0, 0, 0, 0), "err_restart");
        waitReady();
        for (int i = 0; i < 512; i++) begin
            applyStimulus(8'(i), i == 511, 0);
        end
        checkOutput(1, 9'd0,   st(0, 1, 0, 0, 512), "full_status");
        checkOutput(0, 9'd510, 32'hFEFF0001, "wrap_word510");
        checkOutput(0, 9'd0,   32'h00010203, "full_word0");
        pulseStart();
        checkOutput(1, 9'd0, st(1, 0, 0, 0, 0), "reload_hold");

        // Async reset mid-LOAD
        waitReady();
        applyStimulus(8'hCA, 1'b0, 0);
        applyStimulus(8'hFE, 1'b0, 0);
        applyStimulus(8'hBA, 1'b0, 0);
        #2;
        R = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, done, in_ready, ovf_err, byte_count} !== st(1, 0, 0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL async_reset_now: got %b expected %b",
                     {cpu_hold, done, in_ready, ovf_err, byte_count}, st(1, 0, 0, 0, 0));
        end
        checkOutput(1, 9'd0, st(1, 0, 0, 0, 0), "async_reset_status");
        @(posedge clk);
        #1;
        R = 1'b1;
        pulseStart();
        waitReady();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(last_bytes[i], i == 3, 0);
        end
        checkOutput(1, 9'd0, st(0, 1, 0, 0, 4), "after_reset_status");
        checkOutput(0, 9'd0, 32'hDEADBEEF, "after_reset_word0");
        checkOutput(0, 9'd2, 32'hBEEF0000, "after_reset_word2");
        checkOutput(0, 9'd4, 32'h00000000, "after_reset_word4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
